// File: rtl/spi_px_master.sv
`default_nettype none
// ============================================================================
// spi_px_master : SPI mode-0 master streaming pixel bytes into the Sobel core.
//                 Optional macro SPI_PX_BURST_EN keeps CS low across bytes.
// Revision      : 1.0
// ============================================================================
module spi_px_master #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 busy_o,
  output logic                 spi_cs_o,
  output logic                 spi_sck_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i
);

  localparam int                c_bcw      = $clog2(DATA_BITS + 1);
  localparam logic [7:0]        c_setup_ld = 8'(CS_SETUP - 1);
  localparam logic [7:0]        c_div_ld   = 8'(CLK_DIV - 1);
  localparam logic [7:0]        c_hold_ld  = 8'(CS_HOLD - 1);
  localparam logic [c_bcw-1:0]  c_bits_ld  = c_bcw'(DATA_BITS);
  localparam logic [c_bcw-1:0]  c_bit_one  = c_bcw'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_LO = 3'd2,
    SCK_HI = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [c_bcw-1:0]     bits_q, bits_d;
  logic [DATA_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 sdo_q, sdo_d;
  logic                 cs_q, cs_d;
  logic                 sck_q, sck_d;
  logic                 hold_last;
  logic                 ready;
  logic                 accept;

  // Ready is masked by reset so nothing is accepted on the reset edge.
  always_comb begin
    hold_last = (state_q == HOLD) && (cnt_q == 8'd0);
`ifdef SPI_PX_BURST_EN
    ready     = ~reset_i & ((state_q == IDLE) | (hold_last & tx_valid_i));
`else
    ready     = ~reset_i & (state_q == IDLE);
`endif
    accept    = tx_valid_i & ready;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    sdo_d      = sdo_q;
    rx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          cnt_d   = c_setup_ld;
          bits_d  = c_bits_ld;
          tx_sr_d = tx_data_i;
          sdo_d   = tx_data_i[DATA_BITS-1];
        end
      end

      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = SCK_LO;
          cnt_d   = c_div_ld;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SCK_LO: begin
        if (cnt_q == 8'd0) begin
          state_d = SCK_HI;
          cnt_d   = c_div_ld;
          rx_sr_d = {rx_sr_q[DATA_BITS-2:0], spi_sdi_i};
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      SCK_HI: begin
        if (cnt_q == 8'd0) begin
          bits_d = bits_q - c_bit_one;
          if (bits_q > c_bit_one) begin
            state_d = SCK_LO;
            cnt_d   = c_div_ld;
            tx_sr_d = tx_sr_q << 1;
            sdo_d   = tx_sr_q[DATA_BITS-2];
          end else begin
            state_d = HOLD;
            cnt_d   = c_hold_ld;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      HOLD: begin
        if (hold_last) begin
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
`ifdef SPI_PX_BURST_EN
          if (accept) begin
            state_d = SCK_LO;
            cnt_d   = c_div_ld;
            bits_d  = c_bits_ld;
            tx_sr_d = tx_data_i;
            sdo_d   = tx_data_i[DATA_BITS-1];
          end else begin
            state_d = GAP;
          end
`else
          state_d = GAP;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin levels are registered from the next state so they align with it.
    cs_d  = ~((state_d == SETUP) || (state_d == SCK_LO) ||
              (state_d == SCK_HI) || (state_d == HOLD));
    sck_d = (state_d == SCK_HI);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bits_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sdo_q      <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sdo_q      <= sdo_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
    end
  end

  assign tx_ready_o = ready;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign busy_o     = (state_q != IDLE);
  assign spi_cs_o   = cs_q;
  assign spi_sck_o  = sck_q;
  assign spi_sdo_o  = sdo_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_px_master.sv
`default_nettype none
// tb_spi_px_master : randomized scoreboard bench with a behavioural SPI slave
// and a reference model of the expected returned bytes and their timing.
module tb_spi_px_master;

  localparam int DIV = 4, SET = 2, HLD = 2, NB = 8;
  localparam int LAT_IDLE  = SET + 2*DIV*NB + HLD + 1;   // accept in IDLE -> rx_valid
  localparam int LAT_BURST = 2*DIV*NB + HLD + 1;         // accept in HOLD -> rx_valid

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, rx_valid, busy, cs, sck, sdo, sdi, slv_miso;
  logic [7:0] rx_data;
  logic       loop_en = 1'b0;

  logic [7:0] f_data = 8'h00;
  logic       f_valid = 1'b0;
  logic       f_ready, f_rxv, f_busy, f_cs, f_sck, f_sdo;
  logic [7:0] f_rxd;

  int n_vec = 0, n_err = 0, cyc = 0;
  int cs_falls = 0, sck_rises = 0, rv_prev = 0, rv_last = 0;

  typedef struct { logic [7:0] data; int due; } exp_t;
  exp_t       rx_q[$];
  logic [7:0] mosi_q[$];
  exp_t       mon_e;
  logic [7:0] model_reply = 8'h3C;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sdi = loop_en ? sdo : slv_miso;

  spi_px_master u_dut (
    .clk_i(clk), .reset_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .busy_o(busy), .spi_cs_o(cs), .spi_sck_o(sck), .spi_sdo_o(sdo),
    .spi_sdi_i(sdi)
  );

  spi_px_master #(.DATA_BITS(8), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u_fast (
    .clk_i(clk), .reset_i(rst), .tx_data_i(f_data), .tx_valid_i(f_valid),
    .tx_ready_o(f_ready), .rx_data_o(f_rxd), .rx_valid_o(f_rxv),
    .busy_o(f_busy), .spi_cs_o(f_cs), .spi_sck_o(f_sck), .spi_sdo_o(f_sdo),
    .spi_sdi_i(f_sdo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The slave "processes" each received pixel; its reply to the next byte is this.
  function automatic logic [7:0] proc(input logic [7:0] b);
    return {b[3:0], b[7:4]} ^ 8'h5A;
  endfunction

  // Behavioural mode-0 slave: MSB out at CS fall, next bit after each SCK fall.
  logic [7:0] s_reply = 8'h3C, s_sh = 8'h00, s_exp;
  int         s_pos = 0;
  assign slv_miso = s_reply[3'(7 - s_pos)];

  always @(posedge sck) if (cs == 1'b0) s_sh = {s_sh[6:0], sdo};
  always @(posedge cs) s_pos = 0;
  always @(negedge cs) cs_falls++;
  always @(posedge sck) sck_rises++;
  always @(negedge sck) begin
    if (cs == 1'b0) begin
      s_pos++;
      if (s_pos == 8) begin
        s_pos = 0;
        if (mosi_q.size() == 0) chk("mosi_unexpected", {24'h0, s_sh}, 32'hFFFF_FFFF);
        else begin
          s_exp = mosi_q.pop_front();
          chk("mosi_byte", s_sh, s_exp);
        end
        s_reply = proc(s_sh);
      end
    end
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rv_prev = rv_last;
      rv_last = cyc;
      if (rx_q.size() == 0) chk("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else begin
        mon_e = rx_q.pop_front();
        chk("rx_data", rx_data, mon_e.data);
        chk("rx_latency", cyc, mon_e.due);
      end
    end
  end

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic send(input logic [7:0] d, input bit keep_valid);
    int   w = 0;
    exp_t e;
    tx_data  = d;
    tx_valid = 1'b1;
    #1;
    while (tx_ready !== 1'b1) begin
      @(negedge clk); #1; w++;
      if (w > 500) begin
        chk("accept_timeout", tx_ready, 1);
        tx_valid = 1'b0;
        @(negedge clk);
        return;
      end
    end
    e.due  = cyc + ((cs == 1'b0) ? LAT_BURST : LAT_IDLE);
    e.data = loop_en ? d : model_reply;
    model_reply = proc(d);
    rx_q.push_back(e);
    mosi_q.push_back(d);
    @(negedge clk);
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((rx_q.size() != 0 || busy !== 1'b0) && w < 3000) begin
      @(negedge clk); w++;
    end
    if (w >= 3000) begin
      chk("drain_timeout", rx_q.size(), 0);
      rx_q.delete();
      mosi_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: run did not complete (%0d vectors so far)", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         keep;
    int         a, b, w, base, rxv_at;
    logic [7:0] rxd;
    logic [20:0] sck_pat, cs_pat, rxv_pat, exp_sck, exp_cs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_sdo", sdo, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", tx_ready, 1);
    @(negedge clk);

    // Single byte: slave replies 0x3C
    send(8'hA5, 1'b0);
    drain();

    // Reset mid-transaction: frame aborted, no rx_valid
    tx_data = 8'h96; tx_valid = 1'b1;
    #1 chk("abort_ready", tx_ready, 1);
    @(negedge clk); tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs", cs, 1);
    chk("abort_sck", sck, 0);
    chk("abort_ready_low", tx_ready, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_ready_after", tx_ready, 1);
    repeat (80) @(negedge clk);

    // Loopback
    loop_en = 1'b1;
    send(8'h5A, 1'b0);
    send(8'hC3, 1'b0);
    drain();
    loop_en = 1'b0;

    // Backpressure: valid held high across three bytes
    base = cs_falls;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b0);
    drain();
`ifdef SPI_PX_BURST_EN
    chk("bp_frames", cs_falls - base, 1);
`else
    chk("bp_frames", cs_falls - base, 3);
`endif

    // Two bytes back-to-back
    base = cs_falls;
    a    = sck_rises;
    send(8'h81, 1'b1);
    send(8'h7E, 1'b0);
    drain();
    chk("b2b_sck_pulses", sck_rises - a, 16);
`ifdef SPI_PX_BURST_EN
    chk("b2b_frames", cs_falls - base, 1);
    chk("b2b_rx_spacing", rv_last - rv_prev, 2*DIV*NB + HLD);
`else
    chk("b2b_frames", cs_falls - base, 2);
    chk("b2b_rx_spacing", rv_last - rv_prev, LAT_IDLE + 1);
`endif

    // Randomized traffic
    for (int g = 0; g < 5; g++) begin
      loop_en = 1'($urandom_range(0, 1));
      keep    = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        keep = (i < 7) && ($urandom_range(0, 1) == 1);
        send(8'($urandom), keep);
      end
      drain();
    end
    loop_en = 1'b0;

    // Fast timing instance: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, loopback
    f_data = 8'hFF; f_valid = 1'b1;
    #1 chk("fast_ready", f_ready, 1);
    a = cyc;
    @(negedge clk); f_valid = 1'b0;
    sck_pat = '0; cs_pat = '0; rxv_pat = '0; exp_sck = '0; exp_cs = '0;
    rxv_at = -1; rxd = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      sck_pat[k] = f_sck;
      cs_pat[k]  = f_cs;
      rxv_pat[k] = f_rxv;
      exp_sck[k] = (k >= 3) && (k <= 17) && (k % 2 == 1);
      exp_cs[k]  = (k >= 19);
      if (f_rxv === 1'b1 && rxv_at < 0) begin
        rxv_at = k;
        rxd    = f_rxd;
      end
      if (k < 20) @(negedge clk);
    end
    chk("fast_sck_pattern", {11'h0, sck_pat}, {11'h0, exp_sck});
    chk("fast_sck_pulses", $countones(sck_pat), 8);
    chk("fast_cs_pattern", {11'h0, cs_pat}, {11'h0, exp_cs});
    chk("fast_rx_latency", rxv_at, 19);
    chk("fast_rx_data", rxd, 8'hFF);
    chk("fast_rxv_width", $countones(rxv_pat), 1);
    chk("fast_busy_idle", f_busy, 0);
    f_data = 8'h00; f_valid = 1'b1;
    #1 chk("fast_ready2", f_ready, 1);
    b = cyc;
    @(negedge clk); f_valid = 1'b0;
    w = 0;
    while (f_rxv !== 1'b1 && w < 40) begin
      @(negedge clk); w++;
    end
    chk("fast_rx_latency2", cyc - b, 19);
    chk("fast_rx_data2", f_rxd, 8'h00);
    @(negedge clk);
    chk("fast_rxv_pulse", f_rxv, 0);

    repeat (5) @(negedge clk);
    chk("rx_leftover", rx_q.size(), 0);
    chk("mosi_leftover", mosi_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_px_master.md
Name: spi_px_master

Overview:
- Host-side SPI master that drives the pixel SPI slave port of the gray/Sobel core.
- Serialises one pixel byte per transaction on spi_sdo_o (MOSI) and captures the full-duplex returned byte (the previous processed pixel or LFSR config readback) from spi_sdi_i (MISO).
- Used in the FPGA test harness and the system-level bench to stream images into the core.
- SPI mode 0, MSB first, chip select active-low.

Parameters:
- DATA_BITS, 8, transaction width; equals MAX_PIXEL_BITS.
- CLK_DIV, 4, clk_i cycles per SCK half-period; legal range 1..255.
- CS_SETUP, 2, clk_i cycles from CS falling to the first SCK rising edge region; legal range 1..15.
- CS_HOLD, 2, clk_i cycles from the last SCK falling edge to CS rising; legal range 1..15.

Ports:
- clk_i, input, 1, system clock.
- reset_i, input, 1, synchronous active-high reset.
- tx_data_i, input, DATA_BITS, pixel to send.
- tx_valid_i, input, 1, tx_data_i valid.
- tx_ready_o, output, 1, master can accept a transaction.
- rx_data_o, output, DATA_BITS, byte captured from MISO.
- rx_valid_o, output, 1, one-cycle pulse; rx_data_o valid.
- busy_o, output, 1, transaction in progress.
- spi_cs_o, output, 1, chip select, active-low.
- spi_sck_o, output, 1, serial clock; idles low.
- spi_sdo_o, output, 1, MOSI.
- spi_sdi_i, input, 1, MISO; pre-synchronised by the instantiating level.

Behaviour:
- Interface decision: one clock, clk_i; reset_i is synchronous and active-high.
- Reset values:
  - spi_cs_o=1, spi_sck_o=0, spi_sdo_o=0.
  - tx_ready_o=0 in the reset cycle, then 1.
  - rx_valid_o=0, rx_data_o=0, busy_o=0.
- Reset mid-transaction aborts on the next edge: CS deasserts immediately and no rx_valid_o is generated.
- FSM states: IDLE, SETUP, SCK_LO, SCK_HI, HOLD, GAP.
- IDLE:
  - tx_ready_o=1.
  - On tx_valid_i&&tx_ready_o, latch tx_data_i into the shift register and go to SETUP.
  - tx_ready_o is low in every other state.
- SETUP:
  - spi_cs_o=0 and spi_sdo_o=MSB from the first SETUP cycle.
  - Stay CS_SETUP cycles, then go to SCK_LO.
- SCK_LO: spi_sck_o=0 for CLK_DIV cycles, then go to SCK_HI.
- SCK_HI:
  - spi_sck_o=1 for CLK_DIV cycles.
  - On entry, shift spi_sdi_i into the rx shift register LSB.
  - On exit, decrement the bit counter.
  - If bits remain: shift the tx register left, update spi_sdo_o (falling edge), go to SCK_LO.
  - Otherwise go to HOLD.
- HOLD: spi_sck_o=0, spi_cs_o=0 for CS_HOLD cycles, then go to GAP.
- GAP:
  - spi_cs_o=1 for exactly 1 cycle.
  - rx_data_o is updated and rx_valid_o=1 in this cycle.
  - Then go to IDLE.
- Latency: if accepted in cycle 0, rx_valid_o is high in cycle CS_SETUP + 2*CLK_DIV*DATA_BITS + CS_HOLD + 1. With defaults this is cycle 69.
- Throughput: the next accept is possible in the cycle after GAP.
- busy_o=1 in every state except IDLE.
- rx_data_o holds its value until the next GAP.
- tx_valid_i is ignored while not ready; the data is not consumed.
- spi_sdo_o keeps the last driven bit after CS rises. It is held, not tristated.
- The slave synchronises SCK with a 2-FF stage, so the system requires CLK_DIV ≥ 3 relative to the slave clock. The master does not check this.

Optional Feature:
- Macro: SPI_PX_BURST_EN.
- Defined:
  - In HOLD's final cycle, if tx_valid_i=1, tx_ready_o pulses 1.
  - The new byte is accepted, rx_valid_o pulses for the finished byte, and the FSM returns directly to SCK_LO with CS held low. No GAP and no SETUP.
  - Burst latency per byte is 2*CLK_DIV*DATA_BITS + CS_HOLD.
- Not defined: every transaction goes through GAP and CS toggles between bytes.

Test Plan:
- Reset: hold reset_i 3 cycles mid-transaction -> cs=1, sck=0, rx_valid_o never pulses, tx_ready_o=1 on the cycle after reset release.
- Single byte: send tx_data_i=0xA5; slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 stable at each SCK rise; rx_data_o=0x3C with rx_valid_o in cycle 69 after accept.
- Timing: CLK_DIV=1, CS_SETUP=1, CS_HOLD=1 with 0xFF/0x00 -> exactly 8 SCK pulses of 1 high + 1 low cycle; rx_valid_o at cycle 19; cs high gap exactly 1 cycle.
- Backpressure: hold tx_valid_i high with 0x11, 0x22, 0x33 -> three separate CS frames; each byte accepted only when tx_ready_o=1; no byte lost or duplicated.
- Loopback: tie spi_sdo_o to spi_sdi_i and send 0x5A, then 0xC3 -> rx_data_o=0x5A, then 0xC3.
- Burst (SPI_PX_BURST_EN): two bytes 0x81, 0x7E back-to-back -> CS stays low across both; 16 SCK pulses; rx_valid_o pulses twice; second rx_valid_o 2*4*8+2=66 cycles after the first.
